// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mult_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFin
  } state_e;

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: a radix-2 Booth step or a restoring-division step.
// Accumulator layout, multiply: {p_hi[WIDTH:0], p_lo[WIDTH-1:0], q_m1}.
// Accumulator layout, divide:   {1'b0, rem[WIDTH-1:0], quo[WIDTH-1:0], 1'b0}.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               op,
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH+1:0] acc_next,
  output logic               q_bit
);

  localparam int unsigned AW = 2 * WIDTH + 2;

  logic [WIDTH:0]   p_hi;
  logic [WIDTH:0]   p_hi_sum;
  logic [WIDTH:0]   operand_sx;
  logic [AW-1:0]    mul_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_new;
  logic [AW-1:0]    div_next;

  always_comb begin
    // Booth: one extra bit on p_hi so subtracting the most negative operand cannot overflow
    p_hi       = acc[AW-1 -: WIDTH+1];
    operand_sx = {operand[WIDTH-1], operand};
    case (acc[1:0])
      2'b01:   p_hi_sum = p_hi + operand_sx;
      2'b10:   p_hi_sum = p_hi - operand_sx;
      default: p_hi_sum = p_hi;
    endcase
    mul_next = {p_hi_sum[WIDTH], p_hi_sum, acc[WIDTH:1]};

    // Restoring division on magnitudes; rem < operand, so the difference fits in WIDTH bits
    rem       = acc[2*WIDTH -: WIDTH];
    quo       = acc[WIDTH:1];
    rem_shift = {rem, quo[WIDTH-1]};
    fits      = rem_shift >= {1'b0, operand};
    diff      = rem_shift[WIDTH-1:0] - operand;
    rem_new   = fits ? diff : rem_shift[WIDTH-1:0];
    // Quotient LSB is left clear; the caller merges q_bit into it.
    div_next  = {1'b0, rem_new, quo[WIDTH-2:0], 1'b0, 1'b0};

    acc_next = (op == OP_DIV) ? div_next : mul_next;
    q_bit    = (op == OP_DIV) & fits;
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequential signed multiply/divide unit with HI/LO result registers.
// Fixed latency: done pulses in the cycle after the 33rd edge following an accepted start.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = 2 * WIDTH + 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AW-1:0]    acc_step;
  logic             q_bit;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             last_iter;

  mult_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (state_q == StDiv),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    abs_a     = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b     = b[WIDTH-1] ? (~b + 1'b1) : b;
    res_hi    = acc_q[2*WIDTH:WIDTH+1];
    res_lo    = acc_q[WIDTH:1];
    last_iter = cnt_q == CNT_W'(WIDTH - 1);

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          dz_d    = 1'b0;
          neg_a_d = a[WIDTH-1];
          neg_b_d = b[WIDTH-1];
          if (op == OP_MULT) begin
            acc_d   = {{(WIDTH + 1){1'b0}}, b, 1'b0};
            opnd_d  = a;
            state_d = StMul;
          end else begin
            acc_d   = {1'b0, {WIDTH{1'b0}}, abs_a, 1'b0};
            opnd_d  = abs_b;
            state_d = StDiv;
          end
        end
      end
      StMul, StDiv: begin
        if (state_q == StDiv && opnd_q == '0) begin
          dz_d    = 1'b1;
          state_d = StFin;
        end else begin
          acc_d = acc_step | {{(AW - 2){1'b0}}, q_bit, 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (last_iter) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!dz_q) begin
          if (op_q == OP_MULT) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end else begin
            // Truncating division: remainder follows the dividend's sign
            lo_d = (neg_a_q ^ neg_b_q) ? (~res_lo + 1'b1) : res_lo;
            hi_d = neg_a_q ? (~res_hi + 1'b1) : res_hi;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = state_q != StIdle;
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl against a plain-arithmetic reference model.
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;
  logic        ref_dz;

  always #5 clock = ~clock;

  mult_div_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (6)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, p, q, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (mop == OP_MULT) begin
      p      = sa * sb;
      ref_hi = p[63:32];
      ref_lo = p[31:0];
      ref_dz = 1'b0;
    end else if (mb == 32'd0) begin
      ref_dz = 1'b1;
    end else begin
      q      = sa / sb;
      r      = sa % sb;
      ref_lo = q[31:0];
      ref_hi = r[31:0];
      ref_dz = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic mop, input logic [31:0] ma,
                        input logic [31:0] mb);
    int n;
    int exp_lat;
    exp_lat = (mop == OP_DIV && mb == 32'd0) ? 2 : 33;
    @(negedge clock);
    start = 1'b1;
    op    = mop;
    a     = ma;
    b     = mb;
    @(posedge clock);
    #1;
    check({tag, " busy_e0"}, busy, 1);
    check({tag, " dz_clr"}, div_zero, 0);
    model(mop, ma, mb);
    @(negedge clock);
    start = 1'b0;
    op    = 1'($urandom_range(0, 1));
    a     = $urandom;
    b     = $urandom;
    for (n = 1; n <= 60; n++) begin
      @(posedge clock);
      #1;
      check({tag, " overlap"}, busy & done, 0);
      if (done) break;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " hi"}, hi, ref_hi);
    check({tag, " lo"}, lo, ref_lo);
    check({tag, " div_zero"}, div_zero, ref_dz);
    @(posedge clock);
    #1;
    check({tag, " pulse"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int next_acc;
    int exp_done;
    logic        cop;
    logic [31:0] ca, cb;

    reset  = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    a      = '0;
    b      = '0;
    ref_hi = '0;
    ref_lo = '0;
    ref_dz = 1'b0;
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dz", div_zero, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mul -3*5 hi const", hi, 32'hFFFF_FFFF);
    check("mul -3*5 lo const", lo, 32'hFFFF_FFF1);
    run_op("mul min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    check("mul min*min hi const", hi, 32'h4000_0000);
    run_op("div -8/3", OP_DIV, 32'hFFFF_FFF8, 32'd3);
    check("div -8/3 lo const", lo, 32'hFFFF_FFFE);
    run_op("div 100/7", OP_DIV, 32'd100, 32'd7);
    check("div 100/7 lo const", lo, 32'd14);
    run_op("preload", OP_DIV, 32'h451, 32'h20);
    run_op("div by 0", OP_DIV, 32'd5, 32'd0);
    check("div by 0 hi const", hi, 32'h11);
    check("div by 0 lo const", lo, 32'h22);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div ovf lo const", lo, 32'h8000_0000);

    for (int i = 0; i < 24; i++) begin
      logic        rop;
      logic [31:0] ra, rb;
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(0, 15);
        3: ra = {{28{ra[31]}}, ra[3:0]};
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    // start held high with fresh operands every cycle; accepts land every 34 edges
    next_acc = 0;
    exp_done = -1;
    for (int k = 0; k < 3 * 34; k++) begin
      @(negedge clock);
      cop   = 1'($urandom_range(0, 1));
      ca    = $urandom;
      cb    = $urandom;
      if (cb == 32'd0) cb = 32'd1;
      start = 1'b1;
      op    = cop;
      a     = ca;
      b     = cb;
      @(posedge clock);
      #1;
      if (k == next_acc) begin
        model(cop, ca, cb);
        exp_done = k + 33;
        next_acc = k + 34;
      end
      check("hs done", done, (k == exp_done));
      check("hs busy", busy, (k != exp_done));
      if (k == exp_done) begin
        check("hs hi", hi, ref_hi);
        check("hs lo", lo, ref_lo);
      end
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;

    // Asynchronous reset in the middle of a multiply
    @(negedge clock);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd7;
    b     = 32'd9;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst hi", hi, 0);
    check("mid rst lo", lo, 0);
    check("mid rst dz", div_zero, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      check("post rst no done", done, 0);
      check("post rst idle", busy, 0);
    end
    check("post rst hi", hi, 0);
    check("post rst lo", lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Sequential signed multiply/divide unit with its own HI/LO result registers, for the CPU's MULT/DIV instructions.
- The main control unit raises start with an opcode and two operands. The block runs a fixed-length iterative algorithm: radix-2 Booth for multiply, restoring non-performing division for divide.
- It reports busy and a one-cycle done pulse, and holds HI/LO for later MFHI/MFLO reads.
- It replaces the single-cycle combinational multiplier, so the control FSM can stall on busy.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = signed multiply, 1 = signed divide.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; hi/lo (or div_zero) valid from this cycle.
- div_zero  out  1  sticky error flag from the last divide; cleared by the next accepted start.
- hi  out  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
- lo  out  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0.
  - Counter and working registers are cleared.
  - The interrupted operation is discarded, with no done pulse.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - If start = 1 at rising edge E0, latch a, b and op, clear div_zero, set counter = 0, and set busy = 1 from E0.
  - Go to MUL if op = 0, else DIV.
- MUL:
  - Booth radix-2 on the accumulator {P_hi, P_lo, q-1}.
  - Each edge: examine {P_lo[0], q-1}. 01 adds a to P_hi; 10 subtracts a from P_hi. Then arithmetic shift right by 1.
  - Use WIDTH+1-bit add/sub internally so -2^31 is handled.
  - After WIDTH iterations (edges E1..E32), go to FIN.
- DIV:
  - At E1, if latched b == 0: hi and lo are unchanged, div_zero = 1, next state is FIN. The done pulse is then visible after E2.
  - Otherwise, work on magnitudes: |a| and |b|. Each edge performs one restoring step: shift remainder:quotient left by 1, trial-subtract |b|, keep the result if non-negative, and set the quotient bit.
  - WIDTH iterations, then FIN.
  - Sign fix at FIN: quotient is negated if sign(a) XOR sign(b); remainder takes the sign of a (truncating division).
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. Wrap-around, no flag.
- FIN (one cycle):
  - On entry edge E33, hi and lo are written (except on div-by-zero), done = 1 and busy = 0.
  - Next edge: done = 0, state = IDLE.
  - A start seen in FIN is ignored; start is accepted only in IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), i.e. 33 edges after the start edge. Throughput is one operation per 34 cycles.
- start while busy or in FIN is ignored. The operation in flight is unaffected, and a and b may change freely after E0.
- hi and lo hold their value between operations. They change only at FIN, or on reset.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package mult_div_pkg holds:
  - The state enum (IDLE, MUL, DIV, FIN).
  - The op encodings OP_MULT = 1'b0 and OP_DIV = 1'b1.
  - WIDTH_DEFAULT = 32.
- One natural sub-module: mult_div_step, a combinational single iteration.
  - Inputs: op, accumulator, operand.
  - Outputs: the next accumulator, and a quotient bit for divide.
  - This keeps the FSM file small and lets both step types be unit-tested exhaustively at small WIDTH.

Test Plan:
- Reset mid-op: start mult 7 * 9, assert reset at cycle 10 → busy = done = hi = lo = 0 immediately (async); no done pulse afterwards.
- Mult signs: a = -3, b = 5 → done 33 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Also a = b = 0x80000000 → hi = 0x40000000, lo = 0.
- Divide: a = -8, b = 3 → lo = 0xFFFFFFFE (-2), hi = 0xFFFFFFFE (-2). Also a = 100, b = 7 → lo = 14, hi = 2.
- Divide by zero: preload hi = 0x11, lo = 0x22 from a prior op, then start div with b = 0 → done two cycles after start; div_zero = 1; hi = 0x11, lo = 0x22 unchanged. The next start clears div_zero.
- Overflow divide: 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_zero = 0.
- Handshake: start held high continuously with changing operands → exactly one operation per 34 cycles; results match operands sampled at each accepted edge; done never overlaps busy.
